// File: rtl/count_arbiter_ctrl.sv
// count_arbiter_ctrl: two-client arbiter and sequencer for a shared N-bit
// counter. Grants one client, clears the counter with a one-cycle pulse,
// enables counting up to the client's latched length, then signals done.
// A client that drops its request mid-job receives an abort pulse.
//
// Build option:
//   COUNT_ARB_ROUND_ROBIN_EN  defined   -> ties go to the client not last served
//                             undefined -> fixed priority, client 0 wins ties
module count_arbiter_ctrl #(
    parameter int unsigned N = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req,
    input  logic [N-1:0] len0,
    input  logic [N-1:0] len1,
    input  logic [N-1:0] cnt_value,
    output logic         cnt_en,
    output logic         cnt_clr,
    output logic [1:0]   grant,
    output logic         busy,
    output logic [1:0]   done,
    output logic [1:0]   abort
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        FINISH
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] len_q, len_d;
    logic [1:0]   grant_q, grant_d;
    logic         clr_q, clr_d;
    logic [1:0]   abort_q, abort_d;

    // Index of the client currently holding the grant (grant is one-hot
    // whenever it is non-zero, so bit 1 alone identifies the owner).
    logic         owner;
    logic         owner_req;
    // Client selected by arbitration while in IDLE.
    logic         pick;

`ifdef COUNT_ARB_ROUND_ROBIN_EN
    // Client served most recently; reset to 1 so client 0 wins the first tie.
    logic         last_q, last_d;
`endif

    assign owner     = grant_q[1];
    assign owner_req = req[owner];

    // Arbitration: a single request wins outright; ties use the policy.
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
`ifdef COUNT_ARB_ROUND_ROBIN_EN
            2'b11:   pick = ~last_q;
`else
            2'b11:   pick = 1'b0;
`endif
            default: pick = 1'b0;
        endcase
    end

    // Next-state and next-value logic for all registered controls.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        grant_d = grant_q;
        clr_d   = 1'b0;
        abort_d = '0;
`ifdef COUNT_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d = CLEAR;
                    clr_d   = 1'b1;
                    grant_d = pick ? 2'b10 : 2'b01;
                    len_d   = pick ? len1 : len0;
                end
            end
            CLEAR, RUN: begin
                // A dropped owner request takes priority over completion;
                // the counter is not cleared again and simply holds.
                if (!owner_req) begin
                    state_d = IDLE;
                    grant_d = '0;
                    abort_d = grant_q;
`ifdef COUNT_ARB_ROUND_ROBIN_EN
                    last_d  = owner;
`endif
                end else if (state_q == CLEAR) begin
                    state_d = RUN;
                end else if (cnt_value == len_q) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                grant_d = '0;
`ifdef COUNT_ARB_ROUND_ROBIN_EN
                last_d  = owner;
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and control registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            grant_q <= '0;
            clr_q   <= 1'b0;
            abort_q <= '0;
`ifdef COUNT_ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            grant_q <= grant_d;
            clr_q   <= clr_d;
            abort_q <= abort_d;
`ifdef COUNT_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // Outputs decoded from registered state; enable stops at terminal count.
    always_comb begin
        cnt_en  = (state_q == RUN) && (cnt_value != len_q);
        cnt_clr = clr_q;
        grant   = grant_q;
        busy    = (state_q != IDLE);
        done    = (state_q == FINISH) ? grant_q : 2'b00;
        abort   = abort_q;
    end

endmodule

// File: tb/tb_count_arbiter_ctrl.sv
// Testbench for count_arbiter_ctrl: directed vector table, hand-written
// corner sequences, and randomized traffic against a job-timeline model.
module tb_count_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [4:0] len0, len1;
    logic [4:0] cnt;
    logic       cnt_en, cnt_clr, busy;
    logic [1:0] grant, done, abort;

    int errors = 0;
    int checks = 0;

    count_arbiter_ctrl #(.N(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .len0      (len0),
        .len1      (len1),
        .cnt_value (cnt),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    // The shared counter the controller drives (reset by system reset).
    always @(posedge clk or posedge reset) begin
        if (reset)        cnt <= '0;
        else if (cnt_clr) cnt <= '0;
        else if (cnt_en)  cnt <= cnt + 5'd1;
    end

    // Output bundle: {grant[1:0], cnt_clr, cnt_en, busy, done[1:0], abort[1:0]}
    function automatic logic [8:0] outs();
        return {grant, cnt_clr, cnt_en, busy, done, abort};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Reference model: job timeline ----------------
    // While busy, m_t counts cycles since the grant edge (0 = clear cycle).
    // Cycles 1..len enable the counter, len+1 is the terminal-count cycle,
    // len+2 delivers done. A dropped owner request before len+2 aborts.
    bit         m_busy;
    int         m_owner, m_len, m_t, m_last;
    logic [1:0] m_abort;

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_len   = 0;
        m_t     = 0;
        m_last  = 1;
        m_abort = 2'b00;
    endtask

    function automatic logic [1:0] onehot(input int i);
        return (i == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [8:0] exp_out();
        logic [1:0] g, d;
        logic       c, e, b;
        g = 2'b00; d = 2'b00; c = 1'b0; e = 1'b0; b = 1'b0;
        if (m_busy) begin
            g = onehot(m_owner);
            b = 1'b1;
            c = (m_t == 0);
            e = (m_t >= 1) && (m_t <= m_len);
            d = (m_t == m_len + 2) ? g : 2'b00;
        end
        return {g, c, e, b, d, m_abort};
    endfunction

    task automatic model_step(input logic [1:0] r, input logic [4:0] l0, input logic [4:0] l1);
        m_abort = 2'b00;
        if (!m_busy) begin
            if (r != 2'b00) begin
                if (r == 2'b01)      m_owner = 0;
                else if (r == 2'b10) m_owner = 1;
`ifdef COUNT_ARB_ROUND_ROBIN_EN
                else                 m_owner = 1 - m_last;
`else
                else                 m_owner = 0;
`endif
                m_len  = (m_owner == 1) ? int'(l1) : int'(l0);
                m_t    = 0;
                m_busy = 1;
            end
        end else if (m_t <= m_len + 1 && r[m_owner] == 1'b0) begin
            m_busy  = 0;
            m_abort = onehot(m_owner);
            m_last  = m_owner;
        end else if (m_t == m_len + 2) begin
            m_busy = 0;
            m_last = m_owner;
        end else begin
            m_t++;
        end
    endtask

    function automatic logic [4:0] rnd_len();
        if ($urandom_range(0, 9) == 0) return 5'd31;
        return 5'($urandom_range(0, 6));
    endfunction

    // ---------------- Helpers ----------------
    task automatic do_reset();
        req   = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Issue a request and measure grant-to-done latency and counter at done.
    task automatic run_job(input logic [1:0] r, input logic [4:0] l0, input logic [4:0] l1,
                           input bit chg, output int lat, output int cdone);
        bit seen;
        req  = r; len0 = l0; len1 = l1;
        lat  = -1; cdone = -1; seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (grant != 2'b00) seen = 1;
        end
        if (seen) begin
            for (int k = 1; k <= 60; k++) begin
                @(negedge clk);
                if (chg && k == 1) len0 = 5'd1;
                if (done != 2'b00) begin
                    lat   = k;
                    cdone = int'(cnt);
                    break;
                end
            end
        end
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0] req;
        logic [4:0] l0;
        logic [4:0] l1;
        logic [8:0] exp;
        logic [4:0] cnt;
    } vec_t;

    initial begin
        vec_t       tbl[12];
        logic [1:0] tie_exp[3];
        logic [1:0] tie_got[3];
        int         tie_gap[3];
        int         found, idle, lat, cd;
        logic [1:0] prevg;
        bit         hit;

        reset = 1'b1; req = 2'b00; len0 = '0; len1 = '0;

        // Single job len0=3 then a single zero-length job for client 1.
        tbl[0]  = '{2'b01, 5'd3, 5'd0, 9'b01_1_0_1_00_00, 5'd0};
        tbl[1]  = '{2'b01, 5'd3, 5'd0, 9'b01_0_1_1_00_00, 5'd0};
        tbl[2]  = '{2'b01, 5'd3, 5'd0, 9'b01_0_1_1_00_00, 5'd1};
        tbl[3]  = '{2'b01, 5'd3, 5'd0, 9'b01_0_1_1_00_00, 5'd2};
        tbl[4]  = '{2'b01, 5'd3, 5'd0, 9'b01_0_0_1_00_00, 5'd3};
        tbl[5]  = '{2'b01, 5'd3, 5'd0, 9'b01_0_0_1_01_00, 5'd3};
        tbl[6]  = '{2'b00, 5'd3, 5'd0, 9'b00_0_0_0_00_00, 5'd3};
        tbl[7]  = '{2'b00, 5'd3, 5'd0, 9'b00_0_0_0_00_00, 5'd3};
        tbl[8]  = '{2'b10, 5'd3, 5'd0, 9'b10_1_0_1_00_00, 5'd3};
        tbl[9]  = '{2'b10, 5'd3, 5'd0, 9'b10_0_0_1_00_00, 5'd0};
        tbl[10] = '{2'b10, 5'd3, 5'd0, 9'b10_0_0_1_10_00, 5'd0};
        tbl[11] = '{2'b00, 5'd3, 5'd0, 9'b00_0_0_0_00_00, 5'd0};

`ifdef COUNT_ARB_ROUND_ROBIN_EN
        tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01;
`else
        tie_exp[0] = 2'b01; tie_exp[1] = 2'b01; tie_exp[2] = 2'b01;
`endif

        // Reset state.
        @(negedge clk);
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Vector table.
        for (int i = 0; i < 12; i++) begin
            req = tbl[i].req; len0 = tbl[i].l0; len1 = tbl[i].l1;
            @(negedge clk);
            check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].exp));
            check($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(tbl[i].cnt));
        end

        // Tie with both requests held.
        do_reset();
        req = 2'b11; len0 = 5'd2; len1 = 5'd1;
        found = 0; idle = 0; prevg = 2'b00;
        for (int i = 0; i < 3; i++) begin tie_got[i] = 2'b11; tie_gap[i] = -1; end
        for (int k = 0; k < 80 && found < 3; k++) begin
            @(negedge clk);
            if (grant != 2'b00 && prevg == 2'b00) begin
                tie_got[found] = grant;
                tie_gap[found] = idle;
                found++;
                idle = 0;
            end else if (grant == 2'b00) begin
                idle++;
            end
            prevg = grant;
        end
        req = 2'b00;
        for (int i = 0; i < 3; i++)
            check($sformatf("tie_grant%0d", i), 32'(tie_got[i]), 32'(tie_exp[i]));
        check("tie_gap1", 32'(tie_gap[1]), 32'd1);
        check("tie_gap2", 32'(tie_gap[2]), 32'd1);

        // Zero length and full scale.
        do_reset();
        run_job(2'b10, 5'd9, 5'd0, 0, lat, cd);
        check("len0_latency", 32'(lat), 32'd2);
        check("len0_cnt", 32'(cd), 32'd0);
        run_job(2'b01, 5'd31, 5'd0, 0, lat, cd);
        check("full_latency", 32'(lat), 32'd33);
        check("full_cnt", 32'(cd), 32'd31);

        // Mid-job length change is ignored.
        do_reset();
        run_job(2'b01, 5'd4, 5'd0, 1, lat, cd);
        check("lenchg_latency", 32'(lat), 32'd6);
        check("lenchg_cnt", 32'(cd), 32'd4);

        // Abort in RUN with client 1 waiting.
        do_reset();
        req = 2'b11; len0 = 5'd6; len1 = 5'd1;
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (busy && cnt == 5'd2) hit = 1;
        end
        check("abort_pre", 32'(outs()), 32'(9'b01_0_1_1_00_00));
        req = 2'b10;
        @(negedge clk);
        check("abort_pulse", 32'(outs()), 32'(9'b00_0_0_0_00_01));
        @(negedge clk);
        check("abort_regrant", 32'(outs()), 32'(9'b10_1_0_1_00_00));
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-RUN.
        do_reset();
        req = 2'b01; len0 = 5'd6;
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (busy && cnt == 5'd3) hit = 1;
        end
        check("rst_pre", 32'(outs()), 32'(9'b01_0_1_1_00_00));
        #2 reset = 1'b1;
        #1;
        check("rst_async_outs", 32'(outs()), 32'd0);
        check("rst_async_cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run_job(2'b01, 5'd2, 5'd0, 0, lat, cd);
        check("rst_after_latency", 32'(lat), 32'd4);
        check("rst_after_cnt", 32'(cd), 32'd2);

        // Randomized traffic against the timeline model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [8:0] ev;
            logic [1:0] nr;
            ev = exp_out();
            check("rand_outs", 32'(outs()), 32'(ev));
            if (ev[3:2] != 2'b00)
                check("rand_cnt_at_done", 32'(cnt), 32'(m_len));
            nr = req;
            for (int i = 0; i < 2; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) nr[i] = 1'b1;
                end else if (ev[2 + i]) begin
                    if ($urandom_range(0, 1) == 0) nr[i] = 1'b0;
                end else if (m_busy && m_owner == i && m_t <= m_len + 1) begin
                    if ($urandom_range(0, 19) == 0) nr[i] = 1'b0;
                end
            end
            req  = nr;
            len0 = rnd_len();
            len1 = rnd_len();
            @(posedge clk);
            model_step(req, len0, len1);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_arbiter_ctrl.md
# count_arbiter_ctrl

Two-requester controller for the shared N-bit binary counter. It arbitrates between two clients, grants one at a time, and clears the counter with a one-cycle pulse. It then gates the counter enable until the count reaches the granted client's programmed length, and signals completion. It sits between the client logic and the counter instance and is the only driver of the counter's enable and clear.

## Interface
- N, 5, counter width; must match the counter instance width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values
- req  in  2  request per client; must be held high until done or abort for that client
- len0  in  N  terminal count for client 0; sampled at grant
- len1  in  N  terminal count for client 1; sampled at grant
- cnt_value  in  N  current counter output
- cnt_en  out  1  counter enable
- cnt_clr  out  1  counter clear pulse; registered and glitch-free
- grant  out  2  one-hot owner of the counter; 2'b00 when idle
- busy  out  1  high in any state other than IDLE
- done  out  2  one-cycle pulse to the owning client on normal completion
- abort  out  2  one-cycle pulse to the owning client when its req dropped mid-job

## Operation
- Reset values:
  - state IDLE; len_q 0
  - grant, done, abort 2'b00; cnt_en, cnt_clr, busy 0
  - last-served pointer = 1, so client 0 wins the first tie
- FSM states: IDLE, CLEAR, RUN, FINISH.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that client.
  - Both req: grant the client not last served.
  - On grant: latch the client's len into len_q, set grant, go to CLEAR.
- CLEAR (1 cycle): cnt_clr=1, cnt_en=0. Next state is RUN.
- RUN:
  - cnt_en = (cnt_value != len_q), combinational from the state register, len_q and cnt_value.
  - Go to FINISH when cnt_value == len_q.
- FINISH (1 cycle):
  - done[owner]=1, cnt_en=0.
  - Update the last-served pointer to the owner.
  - Clear grant on exit; next state IDLE.
- Abort: if req[owner] falls in CLEAR or RUN:
  - Next cycle: abort[owner]=1, grant cleared, cnt_en=0, state IDLE.
  - The last-served pointer is still updated.
  - The counter is left at its current value.
- Width rule: len_q is N bits. len = 2^N-1 is legal and the counter never wraps. len = 0 gives zero increments: RUN lasts one cycle.
- len inputs are ignored except at grant; changes mid-job have no effect.
- A req that rises while the other client is being served waits. It is considered in IDLE after FINISH or abort.
- The same client may be regranted immediately only if the other req is low.

## Timing
- Request to grant: grant is registered high 1 cycle after req is sampled in IDLE.
- cnt_clr is high during the first cycle of grant.
- RUN lasts len_q+1 cycles, of which len_q have cnt_en=1.
- done pulses the cycle after cnt_value == len_q is first seen.
- Job latency from the grant edge to done high is len_q+2 cycles. Grant falls with done.
- Back-to-back jobs: minimum 1 IDLE cycle between done and the next grant.
- Asynchronous reset mid-job: all outputs take reset values immediately, with no done or abort pulse. The counter must also be reset by the system reset.
- done and abort are never high together, and never in the same cycle as cnt_clr.

## Configuration
- COUNT_ARB_ROUND_ROBIN_EN defined: ties resolve to the client not last served, as above.
- COUNT_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority; client 0 always wins ties.
  - The last-served pointer is not implemented.
  - All other behaviour is identical.

## Test plan
- Single job: req=2'b01, len0=3, after reset → grant=01 next cycle, one cnt_clr pulse, cnt_en high 3 cycles, done=01 at grant+5, grant=00 thereafter, counter holds 3.
- Tie, round-robin: req=2'b11 held, len0=2, len1=1 → grants 01, 10, 01 in order, each separated by one IDLE cycle. Without the macro → 01 repeatedly.
- len=0 and full scale: len1=0 → done 2 cycles after grant with zero increments. len0=31 (N=5) → done at grant+33, no wrap to 0.
- Abort: req0 drops in RUN at cnt_value=2, len0=6 → abort=01 next cycle, no done, cnt_en low, state IDLE, waiting req1 granted the following cycle.
- Reset mid-RUN: assert reset at cnt_value=3 → grant, busy, cnt_en, done, abort all 0 immediately. After release, a new req0 gives a normal job.
- Mid-job len change: change len0 from 4 to 1 during RUN → done only after cnt_value reaches 4.
